// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round constants and key-expansion FSM states.
package aes_pkg;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;
  localparam int NUM_ROUNDS = 10;
  localparam logic [7:0] AES_RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };
  typedef enum logic [2:0] {IDLE, LOAD, SUB, MIX, DONE} keyexp_state_e;
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (GF(2^8) inverse followed by the affine map).
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv      = ginv(in_byte);
  assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule with an 11-entry round-key register file.
// Define AES_KEYEXP_PARALLEL_SBOX_EN to do SubWord with four S-boxes in a single cycle.
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         keys_valid
);
  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  keyexp_state_e state_q, state_d;
  aes_block_t    w_q, w_d, rk_data_q, rk_data_d;
  aes_block_t    rk_q [NUM_ROUNDS+1];
  aes_block_t    rk_d [NUM_ROUNDS+1];
  aes_word_t     tmp_q, tmp_d, rot, t, w0n, w1n, w2n, w3n;
  logic [3:0]    rnd_q, rnd_d;
  logic          start_q;

  assign rot = {w_q[23:0], w_q[31:24]};

`ifdef AES_KEYEXP_PARALLEL_SBOX_EN
  aes_word_t sub;
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.in_byte(rot[8*i +: 8]), .out_byte(sub[8*i +: 8]));
  end
`else
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [4:0] sh;
  logic [7:0] sub_b;
  // Byte 0 is the most significant byte, so its bit offset is 8*(3-byte_cnt).
  assign sh = {~byte_cnt_q, 3'b000};
  aes_sbox u_sbox (.in_byte(rot[sh +: 8]), .out_byte(sub_b));
`endif

  assign t   = tmp_q ^ {AES_RCON[rnd_q], 24'h0};
  assign w0n = w_q[127:96] ^ t;
  assign w1n = w_q[95:64] ^ w0n;
  assign w2n = w_q[63:32] ^ w1n;
  assign w3n = w_q[31:0] ^ w2n;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    tmp_d     = tmp_q;
    rnd_d     = rnd_q;
    rk_d      = rk_q;
    rk_data_d = (rk_addr <= LAST) ? rk_q[rk_addr] : '0;
`ifndef AES_KEYEXP_PARALLEL_SBOX_EN
    byte_cnt_d = byte_cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start & ~start_q) begin
          state_d = LOAD;
          w_d     = key;
          rnd_d   = 4'd1;
        end
      end
      LOAD: begin
        rk_d[0] = w_q;
        state_d = SUB;
`ifndef AES_KEYEXP_PARALLEL_SBOX_EN
        byte_cnt_d = '0;
`endif
      end
      SUB: begin
`ifdef AES_KEYEXP_PARALLEL_SBOX_EN
        tmp_d   = sub;
        state_d = MIX;
`else
        tmp_d[sh +: 8] = sub_b;
        byte_cnt_d     = byte_cnt_q + 2'd1;
        state_d        = (byte_cnt_q == 2'd3) ? MIX : SUB;
`endif
      end
      MIX: begin
        w_d         = {w0n, w1n, w2n, w3n};
        rk_d[rnd_q] = {w0n, w1n, w2n, w3n};
        state_d     = (rnd_q == LAST) ? DONE : SUB;
        rnd_d       = (rnd_q == LAST) ? rnd_q : rnd_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      w_q       <= '0;
      tmp_q     <= '0;
      rnd_q     <= '0;
      start_q   <= 1'b0;
      rk_data_q <= '0;
      rk_q      <= '{default: '0};
`ifndef AES_KEYEXP_PARALLEL_SBOX_EN
      byte_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      tmp_q     <= tmp_d;
      rnd_q     <= rnd_d;
      start_q   <= start;
      rk_data_q <= rk_data_d;
      rk_q      <= rk_d;
`ifndef AES_KEYEXP_PARALLEL_SBOX_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

  assign rk_data    = rk_data_q;
  assign busy       = state_q inside {LOAD, SUB, MIX};
  assign keys_valid = state_q == DONE;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: scoreboard bench for the AES-128 key expander, both S-box builds.
module tb_aes_key_expander;
`ifdef AES_KEYEXP_PARALLEL_SBOX_EN
  localparam int EDGES = 21;
  localparam int RST_AT = 10;
`else
  localparam int EDGES = 51;
  localparam int RST_AT = 30;
`endif
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZRK1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZRK10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [3:0]   rk_addr = '0;
  logic [127:0] rk_data;
  logic         busy, keys_valid;
  int           chk_cnt = 0;
  int           pass_cnt = 0;
  logic [127:0] sb_q[$];
  string        tag_q[$];
  logic [3:0]   rd_a[$];
  logic [127:0] rd_e[$];

  aes_key_expander dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key), .rk_addr(rk_addr),
    .rk_data(rk_data), .busy(busy), .keys_valid(keys_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic queue_rd(input logic [3:0] a, input logic [127:0] e);
    rd_a.push_back(a);
    rd_e.push_back(e);
  endtask

  // Pipelined read: expected value enters the scoreboard with the address, leaves one cycle later.
  task automatic read_port();
    int n;
    logic [3:0] a;
    n = rd_a.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (sb_q.size() > 0) check(tag_q.pop_front(), rk_data, sb_q.pop_front());
      if (i < n) begin
        a = rd_a.pop_front();
        rk_addr = a;
        sb_q.push_back(rd_e.pop_front());
        tag_q.push_back($sformatf("rk_rd[%0d]", a));
      end
    end
  endtask

  task automatic kick(input logic [127:0] k);
    @(negedge clk);
    key = k;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int inject_at, input logic hold, output int n);
    n = 0;
    while (!keys_valid && n < 200) begin
      if (n == 0 && !hold) start = 1'b0;
      if (n == inject_at - 1) begin
        start = 1'b1;
        key = '0;
      end
      if (n == inject_at) start = 1'b0;
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic expand_check(input string nm, input int inject_at, input logic hold);
    int n;
    wait_done(inject_at, hold, n);
    check({nm, "_edges"}, 128'(n), 128'(EDGES));
    check({nm, "_busy_end"}, 128'(busy), 128'(0));
    check({nm, "_valid_end"}, 128'(keys_valid), 128'(1));
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rk_data", rk_data, '0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(keys_valid), 128'(0));
    reset_n = 1'b1;

    kick(FIPS_KEY);
    check("e0_busy", 128'(busy), 128'(1));
    check("e0_valid", 128'(keys_valid), 128'(0));
    expand_check("fips", -1, 1'b0);
    for (int a = 0; a < 16; a++) begin
      if (a <= 10) queue_rd(4'(a), FIPS_RK[a]);
      else queue_rd(4'(a), '0);
    end
    read_port();

    kick('0);
    expand_check("zero", -1, 1'b0);
    queue_rd(4'd0, '0);
    queue_rd(4'd1, ZRK1);
    queue_rd(4'd10, ZRK10);
    read_port();

    kick(FIPS_KEY);
    expand_check("busy_start", 20, 1'b0);
    queue_rd(4'd1, FIPS_RK[1]);
    queue_rd(4'd10, FIPS_RK[10]);
    queue_rd(4'd0, FIPS_KEY);
    read_port();

    kick(FIPS_KEY);
    expand_check("held", -1, 1'b1);
    repeat (10) @(negedge clk);
    check("held_valid", 128'(keys_valid), 128'(1));
    check("held_busy", 128'(busy), 128'(0));
    start = 1'b0;
    kick('0);
    check("restart_valid", 128'(keys_valid), 128'(0));
    check("restart_busy", 128'(busy), 128'(1));
    expand_check("restart", -1, 1'b0);
    queue_rd(4'd10, ZRK10);
    read_port();

    @(negedge clk);
    rk_addr = 4'd10;
    kick(FIPS_KEY);
    start = 1'b0;
    repeat (RST_AT - 1) @(posedge clk);
    #1;
    check("mid_old_rk10", rk_data, ZRK10);
    check("mid_busy", 128'(busy), 128'(1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rk_data", rk_data, '0);
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_valid", 128'(keys_valid), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 16; a++) queue_rd(4'(a), '0);
    read_port();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key schedule for the lab 9 decryption datapath. Sits directly downstream of the Nios II I/O handshake block: it captures the 128-bit `key` when `io_ready` (`start`) rises and expands it into 11 round keys, then flags completion. The inverse-cipher core consumes the round keys in reverse order through a registered random-access read port. A single time-multiplexed S-box keeps area low.

## Interface
- `NUM_ROUNDS`, default 10: AES-128 round count, fixed. The block stores `NUM_ROUNDS+1` round keys.
- `clk  in  1`: clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: expansion request; driven from the I/O block's `io_ready`; edge-detected internally.
- `key  in  128`: cipher key; `key[127:96]` is w0.
- `rk_addr  in  4`: round-key index, 0..10.
- `rk_data  out  128`: round key at `rk_addr`; registered.
- `busy  out  1`: expansion in progress.
- `keys_valid  out  1`: all 11 round keys are stored and stable.

## Operation
- The FSM has five states: IDLE, LOAD, SUB, MIX, DONE.
- **IDLE/DONE → LOAD:** taken on a start rising edge (`start & ~start_q`). `key` is captured into the working words w0..w3. The round counter `rnd` is set to 1 and `keys_valid` is cleared.
- **LOAD → SUB:** `rk[0]` is written with the captured key and `byte_cnt` is set to 0.
- **SUB:** each cycle, one byte of RotWord(w3) = {w3[23:0], w3[31:24]} is passed through the S-box and stored in `tmp[byte_cnt]`, MSB first. After `byte_cnt == 3` the FSM goes to MIX.
- **MIX:** computes the next round key:
  - t = tmp ^ {rcon[rnd], 24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - The new words are stored in w0..w3 and `rk[rnd]`.
  - If `rnd == 10`, go to DONE; otherwise increment `rnd` and return to SUB.
- **rcon[1..10]:** 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. All XOR arithmetic is modulo 2 with no carries.
- **DONE:** `keys_valid` is 1 and the round-key storage is frozen until the next start edge.
- **Read port:**
  - `rk_data <= rk[rk_addr]` every cycle, including while busy.
  - `rk_addr > 10` returns 128'h0.
  - Entries not yet rewritten in the current expansion return their previous contents.
- **Start while busy:** the start edge is ignored, with no restart.
- **Start held high:** does not retrigger; a new low→high transition is required.
- **Reset, any state including mid-expansion:**
  - State → IDLE.
  - All `rk[*]`, w0..w3, `tmp`, `start_q` cleared to 0.
  - `rk_data = 0`, `busy = 0`, `keys_valid = 0`.

## Timing
- Let E0 be the edge at which the start edge is sampled; LOAD is active after E0.
- E1 writes `rk[0]`.
- Each round takes 5 edges: 4 SUB plus 1 MIX. `rk[n]` is written at edge E1+5n.
- `keys_valid` rises at E51 and `busy` falls at E51. `busy` is high from E0 through E51.
- `rk_data` reflects `rk_addr` one cycle after it is presented. It reflects a write one cycle after the write edge.
- The S-box path is combinational within a SUB cycle: `tmp` is registered at the end of the cycle.

## Configuration
- **`AES_KEYEXP_PARALLEL_SBOX_EN`**
  - **Defined:** four S-box instances perform SubWord in a single SUB cycle, and `byte_cnt` is unused. Each round is 2 edges. `rk[n]` is written at E1+2n, and `keys_valid`/`busy` change at E21.
  - **Undefined:** one shared S-box, with the timing above.
- Round-key values, the read port and all boundary behaviour are identical in both builds.

## Structure
- **Shared package `aes_pkg`:**
  - `aes_word_t` (32-bit) and `aes_block_t` (128-bit).
  - The `AES_RCON` constant array.
  - `NUM_ROUNDS`.
  - The state enum `keyexp_state_e`.
- **Sub-module `aes_sbox`:** purely combinational, 8-bit in and 8-bit out. It is shared with the future inverse-cipher core, which uses the forward S-box only in key expansion.
- Round-key storage is an 11×128 register array, not RAM, so reset clearing is mandatory.

## Test plan
- **FIPS-197 vector:** key 2b7e151628aed2a6abf7158809cf4f3c with a start pulse.
  - Expect `keys_valid` at E51.
  - `rk[1]` = a0fafe1788542cb123a339392a6c7605.
  - `rk[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `rk[0]` = the key.
- **Zero key:** expect `rk[1]` = 62636363626363636263636362636363 and `rk[10]` = b4ef5bcb3e92e21123e951cf6f8f188e.
- **Start during busy:** second start edge at E20 with a different key; expect the original FIPS results and completion still at E51.
- **Start held high across DONE:** no restart and `keys_valid` stays 1. Dropping then raising start re-expands: `keys_valid` falls at E0 of the restart.
- **Reset mid-expansion:** assert `reset_n` low at E30; expect all outputs 0 immediately, and `rk_data` 0 for every `rk_addr` after release.
- **Read port:** sweep `rk_addr` 0..15 in DONE; expect each round key with 1-cycle latency, and 0 for addresses 11..15.
- **Build coverage:** rerun all scenarios with `AES_KEYEXP_PARALLEL_SBOX_EN` defined; expect completion at E21.
